add_seq: RTL and testbench
==========================

ADD_SEQ -- requirements
Module: add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4: number of 16-bit words per operand; legal range 1..8.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  16*WORDS  first operand, unsigned.
REQ-007 SHALL have port b  input  16*WORDS  second operand, unsigned.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port sum  output  16*WORDS  result, registered.
REQ-011 SHALL have port carry  output  1  carry out of the most significant word, registered.

Function
REQ-012 SHALL contain exactly one internal 16-bit adder datapath with carry-in, reused once per word; no wider adder.
REQ-013 SHALL implement states IDLE, RUN, DONE with a word index counter idx of width ceil(log2(WORDS)), minimum 1 bit.
REQ-014 SHALL assert in_ready only in IDLE, combinationally from state.
REQ-015 SHALL, on an edge with in_valid and in_ready high, latch a and b, clear the internal carry to 0, set idx to 0, and go to RUN.
REQ-016 SHALL ignore a and b changes after acceptance.
REQ-017 SHALL, on each RUN edge, add word idx of the latched operands with the internal carry, write the 16-bit result into sum word idx, update the internal carry, and increment idx.
REQ-018 SHALL, on the RUN edge processing word WORDS-1, copy the final carry to carry and go to DONE; latency from acceptance edge to out_valid high is exactly WORDS cycles.
REQ-019 SHALL hold out_valid high in DONE only; sum and carry stable while out_valid is high.
REQ-020 SHALL, on an edge with out_valid and out_ready high, go to IDLE; sum and carry keep their values until the next acceptance.
REQ-021 SHALL not accept new operands in DONE or RUN; out_ready in IDLE or RUN has no effect.
REQ-022 SHALL, for WORDS=1, go IDLE->RUN->DONE with a single RUN cycle.
REQ-023 SHALL compute sum = (a+b) mod 2^(16*WORDS) and carry = bit 16*WORDS of a+b.

Reset
REQ-024 SHALL, while rst_n is low, force state IDLE, idx 0, internal carry 0, sum 0, carry 0, out_valid 0; in_ready follows as 1.
REQ-025 SHALL abandon any in-progress RUN or pending DONE on reset assertion; no result is delivered for that operation.

Configuration
REQ-026 SHALL support macro ADD_SEQ_SUB_EN; when defined, add input port op_sub (1 bit) latched at acceptance.
REQ-027 SHALL, with ADD_SEQ_SUB_EN and latched op_sub=1, use inverted b words and initial internal carry 1, giving sum = (a-b) mod 2^(16*WORDS) and carry = 1 when a >= b (no borrow).
REQ-028 SHALL, without ADD_SEQ_SUB_EN, have no op_sub port and perform addition only.

Verification (WORDS=4 unless stated)
REQ-029 SHALL cover: a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0002, out_ready=1 -> out_valid exactly 4 cycles after acceptance, sum=0x...0003, carry=0, IDLE next edge.
REQ-030 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0, carry=1 (carry ripples through all words).
REQ-031 SHALL cover: out_ready held low 10 cycles after out_valid -> out_valid, sum, carry stable, in_ready 0 throughout; in_valid pulses ignored.
REQ-032 SHALL cover: rst_n low at second RUN cycle -> outputs 0, in_ready 1 asynchronously; next operand pair a=0x5,b=0x7 yields sum=0xC, carry=0.
REQ-033 SHALL cover: WORDS=1, a=0x8000, b=0x8000 -> latency 1, sum=0x0000, carry=1.
REQ-034 SHALL cover, with ADD_SEQ_SUB_EN: op_sub=1, a=0x3, b=0x5 -> sum=0xFFFF_FFFF_FFFF_FFFE, carry=0; a=0x5, b=0x3 -> sum=0x2, carry=1.

Source files
------------

// File: rtl/add_seq.sv
// Multi-word adder that reuses a single 16-bit adder, one operand word per clock.
// Define ADD_SEQ_SUB_EN to add the op_sub input for (a-b) mode.
module add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  carry
`ifdef ADD_SEQ_SUB_EN
  ,
  input  logic                  op_sub
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, nstate;
  logic [IW-1:0]           idx;
  logic                    cin;
  logic                    carry_q;
  logic [WORDS-1:0][15:0]  a_q, b_q, sum_q;
  logic [15:0]             aw, bw;
  logic [16:0]             res;
  logic                    last;
`ifdef ADD_SEQ_SUB_EN
  logic                    sub_q;
`endif

  assign sum   = sum_q;
  assign carry = carry_q;
  assign last  = (idx == IW'(WORDS-1));

  // word select feeding the one shared 16-bit adder
  always_comb begin
    aw = '0;
    bw = '0;
    for (int i = 0; i < WORDS; i++)
      if (idx == IW'(i)) begin
        aw = a_q[i];
        bw = b_q[i];
      end
`ifdef ADD_SEQ_SUB_EN
    if (sub_q) bw = ~bw;
`endif
    res = {1'b0, aw} + {1'b0, bw} + {16'd0, cin};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nstate;

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = RUN;
      end
      RUN:  if (last) nstate = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      cin     <= 1'b0;
      carry_q <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          idx <= '0;
`ifdef ADD_SEQ_SUB_EN
          // subtract = a + ~b + 1
          cin   <= op_sub;
          sub_q <= op_sub;
`else
          cin <= 1'b0;
`endif
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++)
            if (idx == IW'(i)) sum_q[i] <= res[15:0];
          cin <= res[16];
          if (last) carry_q <= res[16];
          else      idx     <= idx + 1'b1;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: directed corner cases plus random operands against an
// arithmetic reference; a second WORDS=1 instance covers the single-word case.
module tb_add_seq;
  localparam int WD = 4;
  localparam int W  = 16*WD;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, out_ready = 0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_ready, out_valid, carry;
  logic [W-1:0]  sum;
  logic          op_sub = 0;

  logic          in_valid1 = 0, out_ready1 = 0;
  logic [15:0]   a1 = '0, b1 = '0;
  logic          in_ready1, out_valid1, carry1;
  logic [15:0]   sum1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  add_seq #(.WORDS(WD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry)
`ifdef ADD_SEQ_SUB_EN
    , .op_sub(op_sub)
`endif
  );

  add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry(carry1)
`ifdef ADD_SEQ_SUB_EN
    , .op_sub(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, measure latency, check result, hold, drain.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic sub, input int hold, input string tag);
    logic [W-1:0] es;
    logic         ec;
    int           n;
    if (sub) begin
      es = xa - xb;
      ec = (xa >= xb);
    end else begin
      {ec, es} = {1'b0, xa} + {1'b0, xb};
    end
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, "_rdy"}, {{W{1'b0}}, in_ready}, 1);
    a = xa; b = xb; op_sub = sub; in_valid = 1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 0;
    a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; op_sub = ~sub;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, (W+1)'(n), (W+1)'(WD));
    chk({tag, "_sum"}, {1'b0, sum}, {1'b0, es});
    chk({tag, "_cy"}, {{W{1'b0}}, carry}, {{W{1'b0}}, ec});
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      @(posedge clk); #1;
      chk({tag, "_hvld"}, {{W{1'b0}}, out_valid}, 1);
      chk({tag, "_hsum"}, {carry, sum}, {ec, es});
      chk({tag, "_hrdy"}, {{W{1'b0}}, in_ready}, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_idle"}, {{(W-1){1'b0}}, in_ready, out_valid}, 2);
    chk({tag, "_keep"}, {carry, sum}, {ec, es});
  endtask

  initial begin
    #12;
    chk("rst_rdy", {{W{1'b0}}, in_ready}, 1);
    chk("rst_out", {carry, sum}, 0);
    chk("rst_vld", {{W{1'b0}}, out_valid}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    do_op(64'h1, 64'h2, 0, 0, "small");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, "ripple");
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 10, "hold");

    // reset in the middle of RUN
    a = 64'hFFFF_0000_FFFF_FFFF; b = 64'h1; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("mid_rdy", {{W{1'b0}}, in_ready}, 1);
    chk("mid_vld", {{W{1'b0}}, out_valid}, 0);
    chk("mid_out", {carry, sum}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    do_op(64'h5, 64'h7, 0, 0, "after_rst");

    for (int t = 0; t < 20; t++)
      do_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 0,
            int'($urandom_range(0, 3)), "rnd");

`ifdef ADD_SEQ_SUB_EN
    do_op(64'h3, 64'h5, 1, 0, "sub_neg");
    do_op(64'h5, 64'h3, 1, 0, "sub_pos");
    do_op(64'h7, 64'h7, 1, 1, "sub_eq");
    for (int t = 0; t < 10; t++)
      do_op({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom()),
            int'($urandom_range(0, 2)), "rnd_sub");
`endif

    // single-word instance
    a1 = 16'h8000; b1 = 16'h8000; in_valid1 = 1;
    @(posedge clk); #1; in_valid1 = 0; a1 = 16'h1234;
    chk("w1_run", {{W{1'b0}}, out_valid1}, 0);
    @(posedge clk); #1;
    chk("w1_vld", {{W{1'b0}}, out_valid1}, 1);
    chk("w1_res", {{(W-16){1'b0}}, carry1, sum1}, {{(W-16){1'b0}}, 17'h1_0000});
    out_ready1 = 1;
    @(posedge clk); #1; out_ready1 = 0;
    chk("w1_idle", {{W{1'b0}}, in_ready1}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
